// File: rtl/plot_receiver.sv
// plot_receiver: clips incoming plots, queues them in a FIFO and writes them
// to video memory as linear addresses through a ready/valid write port.
module plot_receiver #(
    parameter int unsigned X_RES      = 160,
    parameter int unsigned Y_RES      = 120,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic [2:0]                    colour,
    input  logic                          writeEn,
    input  logic                          mem_ready,
    output logic                          mem_wren,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [2:0]                    mem_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic [7:0]                    clip_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [9:0]  X_LIM = 10'(X_RES);
    localparam logic [9:0]  Y_LIM = 10'(Y_RES);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] colour;
    } plot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    plot_t               fifo_mem [FIFO_DEPTH];
    plot_t               hold;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                fifo_empty_c, fifo_full_c;
    logic                clip_c, push_req_c, push_acc_c, pop_c;
    logic                wren_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [2:0]          data_nxt;

    // Input-stage classification of the current strobe
    always_comb begin
        fifo_empty_c = (fifo_count == '0);
        fifo_full_c  = (fifo_count == CNT_W'(FIFO_DEPTH));
        clip_c       = writeEn && ((x >= X_LIM) || (y >= Y_LIM));
        push_req_c   = writeEn && !clip_c;
        push_acc_c   = push_req_c && (!fifo_full_c || pop_c);
    end

    assign busy = !fifo_empty_c || (state != IDLE);

    // Write FSM next state, pop request and next registered outputs
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        wren_nxt  = mem_wren;
        addr_nxt  = mem_addr;
        data_nxt  = mem_data;
        case (state)
            IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                addr_nxt  = ADDR_W'(hold.y) * ADDR_W'(X_RES) + ADDR_W'(hold.x);
                data_nxt  = hold.colour;
                wren_nxt  = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                if (mem_ready) begin
                    wren_nxt = 1'b0;
                    if (!fifo_empty_c) begin
                        pop_c     = 1'b1;
                        state_nxt = ADDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, holding registers and memory-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold     <= '0;
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state    <= state_nxt;
            mem_wren <= wren_nxt;
            mem_addr <= addr_nxt;
            mem_data <= data_nxt;
            if (pop_c) begin
                hold <= fifo_mem[rd_ptr];
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_acc_c) begin
            fifo_mem[wr_ptr] <= plot_t'{x: x, y: y, colour: colour};
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge cancel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating clip counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (push_req_c && !push_acc_c) begin
                overflow <= 1'b1;
            end
            if (clip_c && (clip_count != 8'hFF)) begin
                clip_count <= clip_count + 8'd1;
            end
        end
    end

endmodule
